// File: rtl/mul_4to2_pipe.sv
// mul_4to2_pipe: pipelined N x N multiplier with a 4:2-compressor reduction tree.
//
// Pipeline stages:
//   stage 0     : operand/mode/tag capture at accept
//   tree lvl 0  : registered partial-product rows
//                 (Baugh-Wooley terms applied in signed mode)
//   tree lvl 1+ : each level reduces the rows 4:2 and registers the result
//                 (rows run N -> N/2 -> ... -> 2)
//   output      : 2N-bit carry-propagate add registered into product
// Total latency is log2(DATA_LEN)+1 cycles.
//
// The stall is global: when a result is waiting and the consumer is not
// ready, every stage register holds.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready depends only on out_ready/state)
//   in_signed         1 = two's complement operands, 0 = unsigned
//   op1, op2          DATA_LEN-bit operands
//   in_tag            opaque tag carried with the operation
//   out_valid/out_ready result handshake
//   product           2*DATA_LEN-bit product (mod 2^(2N))
//   out_tag           tag of the operation in product
module mul_4to2_pipe #(
    parameter int DATA_LEN = 8,   // 8, 16 or 32
    parameter int TAG_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_signed,
    input  logic [DATA_LEN-1:0]     op1,
    input  logic [DATA_LEN-1:0]     op2,
    input  logic [TAG_LEN-1:0]      in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_LEN-1:0]   product,
    output logic [TAG_LEN-1:0]      out_tag
);

    localparam int W      = 2 * DATA_LEN;
    localparam int LAT    = $clog2(DATA_LEN) + 1;
    localparam int LEVELS = LAT - 2;          // number of 4:2 reduction levels
    localparam int NROWS  = 2 * DATA_LEN - 2; // rows stored over all tree levels

    // All tree levels share one row array. Level l holds DATA_LEN>>l rows,
    // starting at this offset.
    function automatic int level_base(input int lvl);
        return W - (W >> lvl);
    endfunction

    // Row-wise 4:2 compressor over all W columns. Returns {carry_row, sum_row}.
    // cout of each column feeds cin of the next; column 0 has cin = 0.
    // Constant-zero inputs in sparse columns fold into half adders / 3:2 CSAs
    // during synthesis. Carries out of the top column are dropped (mod 2^W).
    function automatic logic [2*W-1:0] compress_4to2(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [W-1:0] c,
        input logic [W-1:0] d
    );
        logic [W-1:0] sum_row;
        logic [W-1:0] cy_vec;
        logic         cin;
        logic         cout;
        logic         t;
        cin     = 1'b0;
        sum_row = '0;
        cy_vec  = '0;
        for (int k = 0; k < W; k++) begin
            t          = a[k] ^ b[k] ^ c[k];
            cout       = (a[k] & b[k]) | (a[k] & c[k]) | (b[k] & c[k]);
            sum_row[k] = t ^ d[k] ^ cin;
            cy_vec[k]  = (t & d[k]) | (t & cin) | (d[k] & cin);
            cin        = cout;
        end
        return {cy_vec << 1, sum_row};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                s0_valid_reg;
    logic                s0_signed_reg;
    logic [DATA_LEN-1:0] s0_op1_reg;
    logic [DATA_LEN-1:0] s0_op2_reg;
    logic [TAG_LEN-1:0]  s0_tag_reg;

    logic [W-1:0]        tree_reg  [NROWS];
    logic [W-1:0]        tree_next [NROWS];
    logic [LEVELS:0]     tree_valid_reg;
    logic [TAG_LEN-1:0]  tree_tag_reg [LEVELS+1];

    logic                out_valid_reg;
    logic [W-1:0]        product_reg;
    logic [TAG_LEN-1:0]  out_tag_reg;

    logic                stall;
    logic [W-1:0]        sum_final;

    assign stall     = out_valid_reg && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_reg;
    assign product   = product_reg;
    assign out_tag   = out_tag_reg;

    // ------------------------------------------------------------------
    // Level 0: partial-product rows from the stage-0 registers.
    // Signed mode: Baugh-Wooley inverts the sign-column terms of rows
    // 0..N-2 and the non-sign terms of row N-1. The two correction ones sit
    // in free slots: bit N of row 0 and bit 2N-1 of row N-1.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DATA_LEN; gi++) begin : g_pp
        logic [W-1:0] pp_row;
        always_comb begin
            pp_row = '0;
            for (int j = 0; j < DATA_LEN; j++) begin
                if ((gi == DATA_LEN - 1) ? (j != DATA_LEN - 1) : (j == DATA_LEN - 1))
                    pp_row[gi + j] = (s0_op1_reg[j] & s0_op2_reg[gi]) ^ s0_signed_reg;
                else
                    pp_row[gi + j] = s0_op1_reg[j] & s0_op2_reg[gi];
            end
            if (gi == 0)
                pp_row[DATA_LEN] = s0_signed_reg;
            if (gi == DATA_LEN - 1)
                pp_row[W-1] = s0_signed_reg;
        end
        assign tree_next[gi] = pp_row;
    end

    // ------------------------------------------------------------------
    // Reduction levels: groups of four rows -> one sum row + one carry row.
    // ------------------------------------------------------------------
    for (genvar gi = 1; gi <= LEVELS; gi++) begin : g_lvl
        for (genvar gj = 0; gj < (DATA_LEN >> (gi + 1)); gj++) begin : g_grp
            localparam int SRC = level_base(gi - 1) + 4 * gj;
            localparam int DST = level_base(gi) + 2 * gj;
            logic [2*W-1:0] cmp;
            assign cmp = compress_4to2(tree_reg[SRC], tree_reg[SRC+1],
                                       tree_reg[SRC+2], tree_reg[SRC+3]);
            assign tree_next[DST]   = cmp[W-1:0];
            assign tree_next[DST+1] = cmp[2*W-1:W];
        end
    end

    // Final carry-propagate add of the last two rows; the carry out is dropped.
    assign sum_final = tree_reg[NROWS-2] + tree_reg[NROWS-1];

    // ------------------------------------------------------------------
    // Control path: valid bits and the output registers (reset).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_reg   <= 1'b0;
            tree_valid_reg <= '0;
            out_valid_reg  <= 1'b0;
            product_reg    <= '0;
            out_tag_reg    <= '0;
        end else if (!stall) begin
            s0_valid_reg   <= in_valid;
            tree_valid_reg <= {tree_valid_reg[LEVELS-1:0], s0_valid_reg};
            out_valid_reg  <= tree_valid_reg[LEVELS];
            // Bubbles do not overwrite the last delivered result.
            if (tree_valid_reg[LEVELS]) begin
                product_reg <= sum_final;
                out_tag_reg <= tree_tag_reg[LEVELS];
            end
        end
    end

    // ------------------------------------------------------------------
    // Data path: operands, rows and tags. These need no reset because the
    // valid bits qualify them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!stall) begin
            s0_op1_reg      <= op1;
            s0_op2_reg      <= op2;
            s0_signed_reg   <= in_signed;
            s0_tag_reg      <= in_tag;
            tree_reg        <= tree_next;
            tree_tag_reg[0] <= s0_tag_reg;
            for (int k = 1; k <= LEVELS; k++)
                tree_tag_reg[k] <= tree_tag_reg[k-1];
        end
    end

endmodule

// File: tb/tb_mul_4to2_pipe.sv
// Self-checking bench for mul_4to2_pipe.
// Runs DATA_LEN = 8, 16 and 32 side by side under shared control, with a
// separate reference model for each width.
//
// Reference model: a queue of pending results, each with an age counter.
// A result is presented once its age reaches LAT. When the presented
// result is not taken, every age freezes.
module tb_mul_4to2_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_signed;
    logic        out_ready;
    logic [3:0]  in_tag;
    logic [31:0] op1_d [3];
    logic [31:0] op2_d [3];
    int          checks = 0;
    int          errors = 0;
    logic        done = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int w,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (DATA_LEN=%0d) at %0t: got %h, expected %h",
                     name, w, $time, act, exp);
        end
    endtask

    // Hand-computed corner operands and products for each width.
    // wi: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit.
    task automatic corner(input int wi, input int idx, output logic [31:0] a,
                          output logic [31:0] b, output logic s,
                          output logic [63:0] e);
        case (wi * 8 + idx)
            0:  {a, b, s, e} = {32'hFF, 32'hFF, 1'b0, 64'hFE01};
            1:  {a, b, s, e} = {32'h00, 32'hA5, 1'b0, 64'h0000};
            2:  {a, b, s, e} = {32'h80, 32'h02, 1'b0, 64'h0100};
            3:  {a, b, s, e} = {32'h80, 32'h80, 1'b1, 64'h4000};
            4:  {a, b, s, e} = {32'hFF, 32'h01, 1'b1, 64'hFFFF};
            5:  {a, b, s, e} = {32'h7F, 32'h80, 1'b1, 64'hC080};
            6:  {a, b, s, e} = {32'hFF, 32'hFF, 1'b1, 64'h0001};
            8:  {a, b, s, e} = {32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE0001};
            9:  {a, b, s, e} = {32'h0000, 32'hA5A5, 1'b0, 64'h0};
            10: {a, b, s, e} = {32'h8000, 32'h0002, 1'b0, 64'h00010000};
            11: {a, b, s, e} = {32'h8000, 32'h8000, 1'b1, 64'h40000000};
            12: {a, b, s, e} = {32'hFFFF, 32'h0001, 1'b1, 64'hFFFFFFFF};
            13: {a, b, s, e} = {32'h7FFF, 32'h8000, 1'b1, 64'hC0008000};
            14: {a, b, s, e} = {32'hFFFF, 32'hFFFF, 1'b1, 64'h00000001};
            16: {a, b, s, e} = {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
            17: {a, b, s, e} = {32'h0, 32'hA5A5A5A5, 1'b0, 64'h0};
            18: {a, b, s, e} = {32'h80000000, 32'h2, 1'b0, 64'h0000000100000000};
            19: {a, b, s, e} = {32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
            20: {a, b, s, e} = {32'hFFFFFFFF, 32'h1, 1'b1, 64'hFFFFFFFFFFFFFFFF};
            21: {a, b, s, e} = {32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};
            22: {a, b, s, e} = {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1};
            default: {a, b, s, e} = {32'h0, 32'h0, 1'b0, 64'h0};
        endcase
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        localparam int DW   = 8 << gi;
        localparam int LATV = $clog2(DW) + 1;

        logic            in_ready_w;
        logic            out_valid_w;
        logic [2*DW-1:0] product_w;
        logic [3:0]      out_tag_w;
        logic [DW-1:0]   op1_w;
        logic [DW-1:0]   op2_w;

        assign op1_w = op1_d[gi][DW-1:0];
        assign op2_w = op2_d[gi][DW-1:0];

        mul_4to2_pipe #(.DATA_LEN(DW), .TAG_LEN(4)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w),
            .in_signed (in_signed),
            .op1       (op1_w),
            .op2       (op2_w),
            .in_tag    (in_tag),
            .out_valid (out_valid_w),
            .out_ready (out_ready),
            .product   (product_w),
            .out_tag   (out_tag_w)
        );

        logic [2*DW-1:0] q_prod [$];
        logic [3:0]      q_tag [$];
        int              q_age [$];
        int              pops = 0;
        int              emitted = 0;
        bit              just_rst = 1'b0;

        // Exact product from ordinary integer arithmetic, reduced to 2N bits.
        function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a,
                                                    input logic [DW-1:0] b,
                                                    input logic sgn);
            logic signed [63:0] x;
            logic signed [63:0] y;
            logic signed [63:0] p;
            if (sgn) begin
                x = 64'($signed(a));
                y = 64'($signed(b));
            end else begin
                x = 64'(a);
                y = 64'(b);
            end
            p = x * y;
            return p[2*DW-1:0];
        endfunction

        // Tie the model to the hand-computed corner products.
        initial begin : p_pin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            logic [63:0] e;
            for (int idx = 0; idx < 7; idx++) begin
                corner(gi, idx, a, b, s, e);
                chk("model_pin", DW, 64'(ref_mul(a[DW-1:0], b[DW-1:0], s)), e);
            end
        end

        // Model update at each rising edge.
        // Inputs and DUT outputs still hold their pre-edge values here.
        initial begin : p_model
            bit ev;
            forever begin
                @(posedge clk);
                if (rst) begin
                    q_prod.delete();
                    q_tag.delete();
                    q_age.delete();
                    just_rst = 1'b1;
                end else begin
                    just_rst = 1'b0;
                    if (out_valid_w && out_ready)
                        emitted++;
                    ev = (q_age.size() > 0) && (q_age[0] == LATV);
                    if (!(ev && !out_ready)) begin
                        if (ev) begin
                            $display("DATA_LEN=%0d result tag=%h product=%h",
                                     DW, q_tag[0], q_prod[0]);
                            void'(q_prod.pop_front());
                            void'(q_tag.pop_front());
                            void'(q_age.pop_front());
                            pops++;
                        end
                        foreach (q_age[i]) q_age[i]++;
                        if (in_valid) begin
                            q_prod.push_back(ref_mul(op1_w, op2_w, in_signed));
                            q_tag.push_back(in_tag);
                            q_age.push_back(0);
                        end
                    end
                end
            end
        end

        // Compare DUT outputs with the model at each falling edge.
        initial begin : p_cmp
            bit ev;
            forever begin
                @(negedge clk);
                ev = (q_age.size() > 0) && (q_age[0] == LATV);
                chk("out_valid", DW, 64'(out_valid_w), 64'(ev));
                chk("in_ready", DW, 64'(in_ready_w), 64'(!(ev && !out_ready)));
                if (ev) begin
                    chk("product", DW, 64'(product_w), 64'(q_prod[0]));
                    chk("out_tag", DW, 64'(out_tag_w), 64'(q_tag[0]));
                end
                if (just_rst) begin
                    chk("rst_product", DW, 64'(product_w), 64'h0);
                    chk("rst_out_tag", DW, 64'(out_tag_w), 64'h0);
                end
            end
        end

        initial begin : p_final
            wait (done);
            chk("emitted_count", DW, 64'(emitted), 64'(pops));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int w = 0; w < 3; w++) begin
            op1_d[w] = $urandom;
            op2_d[w] = $urandom;
        end
    endtask

    initial begin : p_drive
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] e;

        rst = 1'b1;
        in_valid = 1'b0;
        in_signed = 1'b0;
        in_tag = 4'h0;
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            op1_d[w] = 32'h0;
            op2_d[w] = 32'h0;
        end
        repeat (3) step();
        rst = 1'b0;

        // Corner products, back to back.
        for (int idx = 0; idx < 7; idx++) begin
            for (int w = 0; w < 3; w++) begin
                corner(w, idx, a, b, s, e);
                op1_d[w] = a;
                op2_d[w] = b;
                in_signed = s;
            end
            in_tag = 4'(idx);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();

        // Stream 64 random ops in mixed modes; tags wrap at 16.
        for (int i = 0; i < 64; i++) begin
            rand_ops();
            in_signed = 1'($urandom_range(0, 1));
            in_tag = 4'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();

        // Backpressure: 4 ops in flight, then hold the output for 3 cycles.
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            in_signed = 1'($urandom_range(0, 1));
            in_tag = 4'(i + 8);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (12) step();

        // Random valid and random ready.
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            in_signed = 1'($urandom_range(0, 1));
            in_tag = 4'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) step();

        // Reset mid-flight. The op offered during reset must be ignored.
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_tag = 4'(i + 1);
            in_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        rand_ops();
        in_tag = 4'hA;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();

        done = 1'b1;
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
